// File: rtl/kbest_path_sorter_if.sv
// Candidate/survivor stream bundle for kbest_path_sorter.
//   in_valid/in_ready/in_ped/in_path/in_last       : child candidates into the sorter
//   out_valid/out_ready/out_ped/out_path/out_last  : survivors out, ascending PED
// master : the side that supplies candidates and consumes survivors
// slave  : the sorter itself
interface kbest_path_sorter_if #(
  parameter int unsigned ERR_WL  = 16,
  parameter int unsigned PATH_WL = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [ERR_WL-1:0]  in_ped;
  logic [PATH_WL-1:0] in_path;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ERR_WL-1:0]  out_ped;
  logic [PATH_WL-1:0] out_path;
  logic               out_last;

  modport master (
    output in_valid, in_ped, in_path, in_last, out_ready,
    input  in_ready, out_valid, out_ped, out_path, out_last
  );

  modport slave (
    input  in_valid, in_ped, in_path, in_last, out_ready,
    output in_ready, out_valid, out_ped, out_path, out_last
  );
endinterface

// File: rtl/kbest_path_sorter.sv
// K-best survivor selector for one tree level. Candidates {PED, PATH} are
// inserted into a K-deep sorted shift register (slot 0 = smallest PED, ties
// keep arrival order). After the candidate flagged in_last the survivors are
// drained head-first in ascending PED order, then the sorter re-arms.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : kbest_path_sorter_if.slave (candidate in / survivor out streams)
//   cand_cnt  : candidates accepted this level, saturating at all-ones
module kbest_path_sorter #(
  parameter int unsigned K       = 4,
  parameter int unsigned ERR_WL  = 16,
  parameter int unsigned PATH_WL = 8,
  parameter int unsigned CNT_WL  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  kbest_path_sorter_if.slave    bus,
  output logic [CNT_WL-1:0]     cand_cnt
);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t state_q, state_d;

  logic               vld_q  [K];
  logic               vld_d  [K];
  logic [ERR_WL-1:0]  ped_q  [K];
  logic [ERR_WL-1:0]  ped_d  [K];
  logic [PATH_WL-1:0] path_q [K];
  logic [PATH_WL-1:0] path_d [K];
  logic [CNT_WL-1:0]  cand_cnt_q, cand_cnt_d;

  logic [K-1:0] le;        // slot holds a valid PED <= incoming PED
  logic         accept;
  logic         pop;
  logic         next_vld;  // slot behind the head is occupied
  logic         head_last;

  if (K > 1) begin : g_multi
    assign next_vld = vld_q[1];
  end else begin : g_single
    assign next_vld = 1'b0;
  end

  assign accept    = (state_q == COLLECT) && bus.in_valid;
  assign head_last = vld_q[0] && !next_vld;
  assign pop       = (state_q == DRAIN) && vld_q[0] && bus.out_ready;
  assign cand_cnt  = cand_cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (accept && bus.in_last) state_d = DRAIN;
      DRAIN:   if (pop && head_last)      state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_ped   = '0;
    bus.out_path  = '0;
    bus.out_last  = 1'b0;
    unique case (state_q)
      COLLECT: bus.in_ready = 1'b1;
      DRAIN: begin
        bus.out_valid = vld_q[0];
        bus.out_ped   = ped_q[0];
        bus.out_path  = path_q[0];
        bus.out_last  = head_last;
      end
      default: ;
    endcase
  end

  // Slot update. Valid slots always form a sorted prefix, so le[] is a run of
  // ones followed by zeros: slot i keeps its entry if le[i], takes the new
  // entry at the first zero, and otherwise inherits slot i-1.
  always_comb begin
    for (int unsigned i = 0; i < K; i++) begin
      vld_d[i]  = vld_q[i];
      ped_d[i]  = ped_q[i];
      path_d[i] = path_q[i];
      le[i]     = vld_q[i] && (ped_q[i] <= bus.in_ped);
    end
    cand_cnt_d = cand_cnt_q;

    if (accept) begin
      if (cand_cnt_q != '1) cand_cnt_d = cand_cnt_q + CNT_WL'(1);
      if (!le[0]) begin
        vld_d[0]  = 1'b1;
        ped_d[0]  = bus.in_ped;
        path_d[0] = bus.in_path;
      end
      for (int unsigned i = 1; i < K; i++) begin
        if (!le[i]) begin
          if (le[i-1]) begin
            vld_d[i]  = 1'b1;
            ped_d[i]  = bus.in_ped;
            path_d[i] = bus.in_path;
          end else begin
            vld_d[i]  = vld_q[i-1];
            ped_d[i]  = ped_q[i-1];
            path_d[i] = path_q[i-1];
          end
        end
      end
    end else if (pop) begin
      if (head_last) begin
        for (int unsigned i = 0; i < K; i++) vld_d[i] = 1'b0;
        cand_cnt_d = '0;
      end else begin
        for (int unsigned i = 0; i + 1 < K; i++) begin
          vld_d[i]  = vld_q[i+1];
          ped_d[i]  = ped_q[i+1];
          path_d[i] = path_q[i+1];
        end
        vld_d[K-1] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < K; i++) begin
        vld_q[i]  <= 1'b0;
        ped_q[i]  <= '0;
        path_q[i] <= '0;
      end
      cand_cnt_q <= '0;
    end else begin
      vld_q      <= vld_d;
      ped_q      <= ped_d;
      path_q     <= path_d;
      cand_cnt_q <= cand_cnt_d;
    end
  end

endmodule

// File: tb/tb_kbest_path_sorter.sv
module tb_kbest_path_sorter;
  localparam int K       = 4;
  localparam int ERR_WL  = 16;
  localparam int PATH_WL = 8;
  localparam int CNT_WL  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [CNT_WL-1:0] cand_cnt;

  kbest_path_sorter_if #(.ERR_WL(ERR_WL), .PATH_WL(PATH_WL)) bus ();

  kbest_path_sorter #(.K(K), .ERR_WL(ERR_WL), .PATH_WL(PATH_WL), .CNT_WL(CNT_WL)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .cand_cnt (cand_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Current level's candidates, in arrival order
  logic [ERR_WL-1:0]  cand_ped  [$];
  logic [PATH_WL-1:0] cand_path [$];

  task automatic add(input logic [ERR_WL-1:0] p, input logic [PATH_WL-1:0] l);
    cand_ped.push_back(p);
    cand_path.push_back(l);
  endtask

  function automatic logic [ERR_WL-1:0] rand_ped();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return ERR_WL'($urandom_range(0, 7));
      default: return ERR_WL'($urandom);
    endcase
  endfunction

  task automatic send_level();
    int n = cand_ped.size();
    check_eq("in_ready_collect", 32'(bus.in_ready), 1);
    for (int j = 0; j < n; j++) begin
      bus.in_valid = 1'b1;
      bus.in_ped   = cand_ped[j];
      bus.in_path  = cand_path[j];
      bus.in_last  = (j == n - 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Reference: survivors are the min(n,K) smallest PEDs of the level,
  // earlier arrival first among equal PEDs.
  task automatic drain_level(input int stall_min, input int stall_max);
    int n  = cand_ped.size();
    int ne = (n < K) ? n : K;
    int w  = 0;
    bit used [];
    logic [ERR_WL-1:0]  exp_ped  [$];
    logic [PATH_WL-1:0] exp_path [$];
    used = new[n];
    for (int r = 0; r < ne; r++) begin
      int best = -1;
      for (int j = 0; j < n; j++)
        if (!used[j] && (best < 0 || cand_ped[j] < cand_ped[best])) best = j;
      used[best] = 1'b1;
      exp_ped.push_back(cand_ped[best]);
      exp_path.push_back(cand_path[best]);
    end

    while (!bus.out_valid && w < 4) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("drain_out_valid", 32'(bus.out_valid), 1);
    if (!bus.out_valid) return;
    check_eq("drain_in_ready", 32'(bus.in_ready), 0);
    check_eq("cand_cnt", 32'(cand_cnt), (n > 255) ? 255 : n);

    for (int r = 0; r < ne; r++) begin
      int stall = $urandom_range(stall_min, stall_max);
      for (int s = 0; s < stall; s++) begin
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        check_eq("stall_in_ready",  32'(bus.in_ready), 0);
        check_eq("stall_out_valid", 32'(bus.out_valid), 1);
        check_eq("stall_out_ped",   32'(bus.out_ped), 32'(exp_ped[r]));
        check_eq("stall_out_path",  32'(bus.out_path), 32'(exp_path[r]));
      end
      bus.out_ready = 1'b1;
      check_eq("out_valid", 32'(bus.out_valid), 1);
      check_eq("out_ped",   32'(bus.out_ped), 32'(exp_ped[r]));
      check_eq("out_path",  32'(bus.out_path), 32'(exp_path[r]));
      check_eq("out_last",  32'(bus.out_last), (r == ne - 1) ? 1 : 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    check_eq("post_in_ready",  32'(bus.in_ready), 1);
    check_eq("post_out_valid", 32'(bus.out_valid), 0);
    check_eq("post_cand_cnt",  32'(cand_cnt), 0);
  endtask

  task automatic run_level(input int stall_min, input int stall_max);
    send_level();
    drain_level(stall_min, stall_max);
    cand_ped.delete();
    cand_path.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_in_ready"},  32'(bus.in_ready), 1);
    check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check_eq({tag, "_out_last"},  32'(bus.out_last), 0);
    check_eq({tag, "_out_ped"},   32'(bus.out_ped), 0);
    check_eq({tag, "_out_path"},  32'(bus.out_path), 0);
    check_eq({tag, "_cand_cnt"},  32'(cand_cnt), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_ped    = '0;
    bus.in_path   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_state("reset");
    rst = 1'b0;

    // Mixed PEDs with a tie, more candidates than K
    add(9, 0); add(3, 1); add(7, 2); add(1, 3); add(5, 4); add(3, 5);
    run_level(0, 0);

    // Fewer candidates than K
    add(10, 0); add(4, 1);
    run_level(0, 0);

    // Downstream stall of three cycles on every survivor
    add(20, 9); add(2, 8); add(11, 7); add(6, 6); add(30, 5);
    run_level(3, 3);

    // All-ones PEDs: valid values, stable among ties
    for (int j = 0; j < 5; j++) add('1, PATH_WL'(j));
    run_level(0, 1);

    // Reset in the middle of collecting discards partial level
    for (int j = 0; j < 3; j++) begin
      bus.in_valid = 1'b1;
      bus.in_ped   = ERR_WL'(j);
      bus.in_path  = PATH_WL'(j);
      bus.in_last  = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("midreset");
    rst = 1'b0;

    // in_last without in_valid is ignored
    bus.in_last = 1'b1;
    @(posedge clk); #1;
    bus.in_last = 1'b0;
    check_eq("lone_last_in_ready",  32'(bus.in_ready), 1);
    check_eq("lone_last_out_valid", 32'(bus.out_valid), 0);

    add(8, 7);
    run_level(0, 0);

    // Back-to-back random levels
    for (int lv = 0; lv < 30; lv++) begin
      int n = $urandom_range(1, 10);
      for (int j = 0; j < n; j++) add(rand_ped(), PATH_WL'($urandom));
      run_level(0, 2);
    end

    // Candidate counter saturation
    for (int j = 0; j < 300; j++) add(rand_ped(), PATH_WL'($urandom));
    run_level(0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
